pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 4-stage 16-bit pipeline: S1 IF/ID, S2 ID/EX, S3 EX/MEM, S4 MEM/WB.
- Drives per-stage enable and flush/bubble controls into the pipeline register stages.
- Detects load-use hazards and applies branch-taken flushes.
- Freezes the pipeline while the data memory access in S3 is pending, with a timeout error trap and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 64: max consecutive mem-wait cycles before the error trap; legal range 2..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- id_ra_a  in  5  source register A of the instruction in ID.
- id_ra_b  in  5  source register B of the instruction in ID.
- id_uses_a  in  1  ID instruction reads ra_a.
- id_uses_b  in  1  ID instruction reads ra_b.
- ex_wa  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- br_taken  in  1  branch resolved taken in EX this cycle.
- mem_req  in  1  S3 instruction accesses data memory (load or store).
- mem_ready  in  1  data memory completes the S3 access this cycle.
- pc_en  out  1  PC update enable.
- s1_en  out  1  S1 register enable.
- s2_en  out  1  S2 register enable.
- s3_en  out  1  S3 register enable.
- s1_flush  out  1  S1 loads NOP.
- s2_flush  out  1  S2 loads bubble.
- s4_bubble  out  1  S4 loads bubble (no writeback).
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 after startup.
- flush_count  out  CNT_W  saturating count of branch flush events.
- mem_timeout_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=RUN, run_q=0, wait_cnt=0, both counters=0, mem_timeout_err=0.
  - All *_en=0, all flush/bubble outputs=0.
- run_q becomes 1 on the first rising edge after rst deasserts. While run_q=0, enables and flushes stay 0 and the counters do not count.
- Outputs are combinational from state, run_q and current inputs; the FSM and counters are registered.
- Priority in RUN, highest first:
  - Memory wait: mem_req=1 and mem_ready=0.
    - pc_en=s1_en=s2_en=s3_en=0, s4_bubble=1, s1_flush=s2_flush=0.
    - Next state MEM_WAIT; wait_cnt<=1.
  - Branch flush: br_taken=1.
    - All enables=1, s1_flush=1, s2_flush=1.
    - flush_count increments (saturates at all-ones).
  - Load-use stall: ex_mem_read=1, ex_wa!=0, and either (id_uses_a and id_ra_a==ex_wa) or (id_uses_b and id_ra_b==ex_wa).
    - pc_en=0, s1_en=0, s2_en=1, s2_flush=1, s3_en=1.
    - Exactly one cycle: the load advances to S3, so the condition clears.
  - Otherwise: all enables=1, all flush/bubble outputs=0.
- Register 0 never creates a hazard.
- MEM_WAIT:
  - mem_ready=0: freeze outputs as above; wait_cnt increments.
    - If wait_cnt==MEM_TIMEOUT-1 on this edge, next state is ERR and mem_timeout_err<=1.
  - mem_ready=1: release cycle. The RUN priority list is evaluated with current inputs (mem wait term false). Next state RUN, wait_cnt<=0.
  - br_taken and the load-use condition are ignored while frozen. They are acted on in the release cycle, because the EX contents are held.
- ERR:
  - All enables=0, s4_bubble=1, other flushes 0.
  - Terminal until reset; mem_timeout_err stays 1.
- stall_cycles:
  - Increments every cycle with run_q=1 and pc_en=0 (load-use, MEM_WAIT, ERR).
  - Saturates at all-ones and never wraps.
- mem_req deasserting in MEM_WAIT without mem_ready is protocol-illegal. The block treats it as mem_ready=1.
- Reset asserted mid-stall or in ERR returns everything to reset values immediately.

Test Plan:
- Reset release, idle inputs: cycle 0 after deassert all enables=0; from cycle 1 pc_en=s1_en=s2_en=s3_en=1, counters stay 0.
- Load-use, ex_mem_read=1, ex_wa=5, id_ra_b=5, id_uses_b=1: one cycle pc_en=0, s1_en=0, s2_flush=1; stall_cycles=1. Repeat with ex_wa=0: no stall.
- Branch plus simultaneous load-use hazard (br_taken=1): s1_flush=s2_flush=1, pc_en=1, no stall; flush_count=1.
- mem_req=1, mem_ready=0 for 3 cycles then 1, with br_taken=1 held:
  - 3 frozen cycles with s4_bubble=1.
  - Release cycle shows s1_flush=s2_flush=1.
  - stall_cycles=3, flush_count=1.
- MEM_TIMEOUT=4, mem_ready stuck 0: ERR entered after 4 frozen cycles; mem_timeout_err=1 persists; a rst pulse clears it and the state returns to RUN.
- CNT_W=4, 20 load-use stalls: stall_cycles saturates at 15 and never wraps.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 4-stage pipeline: load-use, branch
// flush, data-memory freeze with timeout trap, perf counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_ra_a,
  input  logic [4:0]       i_id_ra_b,
  input  logic             i_id_uses_a,
  input  logic             i_id_uses_b,
  input  logic [4:0]       i_ex_wa,
  input  logic             i_ex_mem_read,
  input  logic             i_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_en,
  output logic             o_s1_en,
  output logic             o_s2_en,
  output logic             o_s3_en,
  output logic             o_s1_flush,
  output logic             o_s2_flush,
  output logic             o_s4_bubble,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_ERR
  } state_t;

  localparam logic [15:0] WC_LAST = 16'(MEM_TIMEOUT - 1);

  state_t           r_state;
  logic             r_run_q;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;
  logic             r_err;

  logic w_hit_a;
  logic w_hit_b;
  logic w_hazard;
  logic w_freeze;
  logic w_trap;
  logic w_live;
  logic w_br;
  logic w_ldu;

  assign w_hit_a  = i_id_uses_a && (i_id_ra_a == i_ex_wa);
  assign w_hit_b  = i_id_uses_b && (i_id_ra_b == i_ex_wa);
  assign w_hazard = i_ex_mem_read && (i_ex_wa != 5'd0)
                 && (w_hit_a || w_hit_b);

  // mem_req dropping while waiting counts as completion
  assign w_freeze = r_run_q && (r_state != ST_ERR)
                 && i_mem_req && !i_mem_ready;
  assign w_trap   = r_run_q && (r_state == ST_ERR);
  assign w_live   = r_run_q && (r_state != ST_ERR) && !w_freeze;
  assign w_br     = w_live && i_br_taken;
  assign w_ldu    = w_live && !i_br_taken && w_hazard;

  assign o_pc_en     = w_live && !w_ldu;
  assign o_s1_en     = w_live && !w_ldu;
  assign o_s2_en     = w_live;
  assign o_s3_en     = w_live;
  assign o_s1_flush  = w_br;
  assign o_s2_flush  = w_br || w_ldu;
  assign o_s4_bubble = w_freeze || w_trap;

  assign o_stall_cycles    = r_stall;
  assign o_flush_count     = r_flush;
  assign o_mem_timeout_err = r_err;

  // Startup gate, memory-wait tracking and terminal error trap
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_RUN;
      r_run_q    <= 1'b0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (!r_run_q) begin
      r_run_q <= 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_freeze) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 16'd1;
          end
        end
        ST_WAIT: begin
          if (w_freeze) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            if (r_wait_cnt == WC_LAST) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating stall and branch-flush counters
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (r_run_q && !o_pc_en && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
      if (w_br && (r_flush != '1))
        r_flush <= r_flush + 1'b1;
    end
  end

endmodule
